// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_pkg
//  Description : Shared constants and state encoding for the streaming
//                popcount accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
package popcount_pkg;

    // Default accumulator / result width
    localparam int ACC_WIDTH_DEFAULT = 16;

    // Width of a single 64-bit word popcount (0..64 needs 7 bits)
    localparam int PC_WIDTH = 7;

    // Frame state machine encoding
    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [1:0] ST_ACCUM = 2'b00;  // accepting words of a frame
    localparam logic [1:0] ST_DRAIN = 2'b01;  // last word still in stage 1
    localparam logic [1:0] ST_DONE  = 2'b10;  // result presented downstream

endpackage : popcount_pkg
`default_nettype wire

// File: rtl/popcount_int64.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_int64
//  Description : Purely combinational population count of a 64-bit word,
//                built as a balanced binary adder tree (2/3/4/5/6/7 bits).
//  Revision    : 1.0  initial release
// ============================================================================
module popcount_int64
    import popcount_pkg::*;
(
    input  logic [63:0]          A,
    output logic [PC_WIDTH-1:0]  Y
);

    // Each level halves the number of partial counts and widens them by 1.
    logic [1:0] w_l1 [32];
    logic [2:0] w_l2 [16];
    logic [3:0] w_l3 [8];
    logic [4:0] w_l4 [4];
    logic [5:0] w_l5 [2];

    generate
        for (genvar i = 0; i < 32; i++) begin : g_l1
            assign w_l1[i] = {1'b0, A[2*i]} + {1'b0, A[2*i+1]};
        end
        for (genvar i = 0; i < 16; i++) begin : g_l2
            assign w_l2[i] = {1'b0, w_l1[2*i]} + {1'b0, w_l1[2*i+1]};
        end
        for (genvar i = 0; i < 8; i++) begin : g_l3
            assign w_l3[i] = {1'b0, w_l2[2*i]} + {1'b0, w_l2[2*i+1]};
        end
        for (genvar i = 0; i < 4; i++) begin : g_l4
            assign w_l4[i] = {1'b0, w_l3[2*i]} + {1'b0, w_l3[2*i+1]};
        end
        for (genvar i = 0; i < 2; i++) begin : g_l5
            assign w_l5[i] = {1'b0, w_l4[2*i]} + {1'b0, w_l4[2*i+1]};
        end
    endgenerate

    assign Y = {1'b0, w_l5[0]} + {1'b0, w_l5[1]};

endmodule : popcount_int64
`default_nettype wire

// File: rtl/popcount_stream_accum.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_stream_accum
//  Description : Counts set bits over a framed stream of 64-bit words.
//                Stage 1 registers each accepted word's popcount; stage 2
//                accumulates with saturation. The frame total is held on the
//                output handshake until taken, back-pressuring the input.
//  Revision    : 1.0  initial release
// ============================================================================
module popcount_stream_accum
    import popcount_pkg::*;
#(
    parameter int WIDTH     = 64,                 // only 64 is supported
    parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_sat
);

    localparam logic [ACC_WIDTH-1:0] c_ACC_MAX = {ACC_WIDTH{1'b1}};

    state_t                r_state;
    logic                  r_s1_valid;
    logic [PC_WIDTH-1:0]   r_s1_pc;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_sat;

    logic                  w_accept;
    logic                  w_out_take;
    logic [PC_WIDTH-1:0]   w_pc;
    logic [ACC_WIDTH-1:0]  w_pc_ext;
    logic [ACC_WIDTH:0]    w_sum;

    // Word-level popcount, purely combinational
    popcount_int64 u_popcount (
        .A (in_data),
        .Y (w_pc)
    );

    assign in_ready   = (r_state == ST_ACCUM);
    assign out_valid  = (r_state == ST_DONE);
    assign out_sum    = r_acc;
    assign out_sat    = r_sat;

    assign w_accept   = in_valid && in_ready;
    assign w_out_take = out_valid && out_ready;

    // One extra carry bit detects overflow of the accumulator
    assign w_pc_ext = {{(ACC_WIDTH-PC_WIDTH){1'b0}}, r_s1_pc};
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_pc_ext};

    // Frame state: ACCUM -> DRAIN on last word, DRAIN -> DONE, DONE -> ACCUM on take
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_accept && in_last) r_state <= ST_DRAIN;
                ST_DRAIN: r_state <= ST_DONE;
                ST_DONE:  if (out_ready) r_state <= ST_ACCUM;
                default:  r_state <= ST_ACCUM;
            endcase
        end
    end

    // Stage 1: capture popcount of each accepted word; valid clears on idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_pc    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_pc <= w_pc;
            end
        end
    end

    // Stage 2: saturating accumulate with sticky overflow flag; cleared on result take
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (w_out_take) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (r_s1_valid) begin
            if (w_sum[ACC_WIDTH]) begin
                r_acc <= c_ACC_MAX;
                r_sat <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_WIDTH-1:0];
            end
        end
    end

endmodule : popcount_stream_accum
`default_nettype wire

// File: tb/tb_popcount_stream_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_popcount_stream_accum
//  Description : Self-checking bench: table-driven frames, directed corner
//                sequences and random frames, with results checked through
//                an expected-result queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_popcount_stream_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_sat;

    int tests = 0;
    int fails = 0;

    typedef struct { int sum; bit sat; } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [63:0] w0, w1, w2, w3;
        int          n;
        int          exp_sum;
    } vec_t;

    bit rnd_or = 1'b0;

    popcount_stream_accum #(.WIDTH(64), .ACC_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor: sample mid-cycle, the handshake completes on the next edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got sum %0d expected no result at %0t", out_sum, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_sum", out_sum, e.sum);
                chk("out_sat", out_sat, e.sat);
            end
        end
    end

    // Random consumer back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_or) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one word, wait (bounded) for acceptance; returns whether it stalled
    task automatic send(input logic [63:0] d, input bit last, output bit stalled);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        stalled  = !in_ready;
        while (!in_ready && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 at %0t", $time);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drained();
        int guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_out_valid();
        int guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("out_valid_wait", out_valid, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [6];
        logic [63:0] words [4];
        bit          st;
        int          any_stall;
        int          total;
        logic [63:0] d;

        tbl[0] = '{64'h1, 64'h3, 64'h0, 64'hF0F0, 4, 11};
        tbl[1] = '{64'h0, 64'h0, 64'h0, 64'h0, 1, 0};
        tbl[2] = '{64'h8000_0000_0000_0001, 64'h0, 64'h0, 64'h0, 1, 2};
        tbl[3] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'h0, 64'h0, 2, 64};
        tbl[4] = '{64'h0, 64'h0, 64'h0, 64'h1, 4, 1};
        tbl[5] = '{64'hFF00_0000_0000_00FF, 64'h0000_FFFF_0000_0000, 64'h7, 64'h0, 3, 35};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_sum",   out_sum,   0);
        chk("reset_out_sat",   out_sat,   0);
        chk("reset_in_ready",  in_ready,  1);

        // Single all-ones word: result exactly two edges after acceptance
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, st);
        sb.push_back('{64, 1'b0});
        chk("lat_after_accept_edge", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_second_edge", out_valid, 1);
        chk("lat_in_ready_low", in_ready, 0);
        wait_drained();
        @(posedge clk); #1;

        // Table frames, back-to-back words
        for (int t = 0; t < 6; t++) begin
            words[0] = tbl[t].w0; words[1] = tbl[t].w1;
            words[2] = tbl[t].w2; words[3] = tbl[t].w3;
            any_stall = 0;
            for (int j = 0; j < tbl[t].n; j++) begin
                send(words[j], (j == tbl[t].n - 1), st);
                if (st) any_stall++;
                if (j == tbl[t].n - 1) sb.push_back('{tbl[t].exp_sum, 1'b0});
            end
            chk("tbl_no_stall", any_stall, 0);
            wait_drained();
            @(posedge clk); #1;
        end

        // 1023 all-ones words: just below saturation
        for (int j = 0; j < 1023; j++) send({64{1'b1}}, (j == 1022), st);
        sb.push_back('{65472, 1'b0});
        wait_drained();
        @(posedge clk); #1;

        // 1024 all-ones words: overflows, saturates
        for (int j = 0; j < 1024; j++) send({64{1'b1}}, (j == 1023), st);
        sb.push_back('{65535, 1'b1});
        wait_drained();
        @(posedge clk); #1;

        // Held result under back-pressure
        out_ready = 1'b0;
        send(64'hFF, 1'b1, st);
        sb.push_back('{8, 1'b0});
        wait_out_valid();
        for (int k = 0; k < 5; k++) begin
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_sum",   out_sum,   8);
            chk("stall_in_ready",  in_ready,  0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", in_ready, 1);
        chk("release_acc_clear", out_sum, 0);
        send(64'h3, 1'b1, st);
        sb.push_back('{2, 1'b0});
        wait_drained();
        @(posedge clk); #1;

        // Reset mid-frame discards the partial frame
        send(64'hF, 1'b0, st);
        send(64'hFF, 1'b0, st);
        send(64'hFFF, 1'b0, st);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_sum",  out_sum,  0);
        chk("midrst_in_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            chk("midrst_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        send(64'h7, 1'b1, st);
        sb.push_back('{3, 1'b0});
        wait_drained();
        @(posedge clk); #1;

        // Reset while a result is pending: it must never appear
        out_ready = 1'b0;
        send(64'hF, 1'b1, st);
        wait_out_valid();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("pendrst_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end

        // Random frames with input gaps and consumer back-pressure
        rnd_or = 1'b1;
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(1, 50);
            total = 0;
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                case ($urandom_range(0, 3))
                    0:       d = '1;
                    1:       d = '0;
                    default: d = {$urandom, $urandom};
                endcase
                total += $countones(d);
                send(d, (j == n - 1), st);
            end
            sb.push_back('{(total > 65535) ? 65535 : total, (total > 65535)});
        end
        wait_drained();
        rnd_or = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("final_idle_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_popcount_stream_accum
`default_nettype wire

// File: doc/popcount_stream_accum.md
POPCOUNT_STREAM_ACCUM -- requirements
Module: popcount_stream_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 64: input word width; only 64 is supported.
REQ-002 SHALL have parameter ACC_WIDTH, default 16: accumulator and result width.
REQ-003 SHALL have one clock and a synchronous, active-high reset; clk input 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have rst input 1: synchronous active-high reset.
REQ-005 SHALL have in_valid input 1: in_data and in_last are valid.
REQ-006 SHALL have in_ready output 1: block accepts a word this cycle.
REQ-007 SHALL have in_data input WIDTH: word whose set bits are counted.
REQ-008 SHALL have in_last input 1: word is the final word of the current frame.
REQ-009 SHALL have out_valid output 1: frame result is available.
REQ-010 SHALL have out_ready input 1: consumer takes the result.
REQ-011 SHALL have out_sum output ACC_WIDTH: total set bits in the frame.
REQ-012 SHALL have out_sat output 1: frame total exceeded 2^ACC_WIDTH-1.

Function
REQ-013 SHALL accept a word on each rising edge where in_valid && in_ready are both 1.
REQ-014 SHALL implement states ACCUM, DRAIN and DONE; in_ready SHALL be 1 only in ACCUM.
REQ-015 SHALL implement stage 1 as: on accept, register the 7-bit popcount of in_data (0..64) and set a stage-1 valid bit; with no accept, clear the valid bit.
REQ-016 SHALL implement stage 2 as: when stage-1 valid is set, acc <= acc + popcount, zero-extended to ACC_WIDTH.
REQ-017 SHALL saturate acc at 2^ACC_WIDTH-1 on overflow and set a sticky sat flag for the frame.
REQ-018 SHALL move ACCUM->DRAIN when the accepted word has in_last=1; SHALL move DRAIN->DONE on the next edge, as stage 2 absorbs the last word.
REQ-019 SHALL assert out_valid only in DONE, with out_sum=acc and out_sat=sat; both outputs SHALL stay stable until the handshake.
REQ-020 SHALL assert out_valid exactly 2 cycles after the in_last word is accepted, if out_ready was never low.
REQ-021 SHALL, on an edge where out_valid && out_ready are both 1, clear acc and sat to 0 and move DONE->ACCUM; in_ready SHALL be 1 in the following cycle.
REQ-022 SHALL, while out_ready=0 in DONE, hold state and keep in_ready=0 (back-pressure upstream).
REQ-023 SHALL sustain one accepted word per cycle within a frame, with no bubbles required.
REQ-024 SHALL accept a one-word frame (in_last on the first word) and produce that word's popcount.
REQ-025 SHALL treat an all-zero word as contributing 0 and still advance the frame.
REQ-026 SHALL ignore in_data and in_last whenever no accept occurs.

Reset
REQ-027 SHALL, while rst=1, drive state to ACCUM and clear acc, sat and stage-1 valid to 0; out_valid=0, out_sum=0, out_sat=0, in_ready=1 after reset.
REQ-028 SHALL discard any partial frame and any pending result when reset is asserted mid-operation; no result for that frame SHALL ever appear.
REQ-029 SHALL give rst priority over every simultaneous handshake.

Structure
REQ-030 SHALL take ACC_WIDTH default, popcount width (7) and the state enumeration from shared package popcount_pkg.
REQ-031 SHALL compute the stage-1 popcount with one combinational sub-module instance, popcount_int64 (A=in_data, Y=7-bit count).
REQ-032 SHALL keep all registers in this module; the sub-module SHALL stay purely combinational.

Verification
REQ-033 SHALL cover: a single word 64'hFFFF_FFFF_FFFF_FFFF with in_last=1 -> out_valid 2 cycles later, out_sum=64, out_sat=0.
REQ-034 SHALL cover: 4 back-to-back words 64'h1, 64'h3, 64'h0, 64'hF0F0 with the last flagged -> out_sum=11; in_ready high for all 4 cycles.
REQ-035 SHALL cover: 1023 all-ones words -> out_sum=65472, out_sat=0; then 1024 all-ones words -> out_sum=65535, out_sat=1.
REQ-036 SHALL cover: result pending with out_ready=0 for 5 cycles -> out_sum stable, in_ready=0 throughout; on release, the next frame starts with acc=0.
REQ-037 SHALL cover: rst pulsed after 3 words of a frame -> no out_valid; a new frame of word 64'h7 -> out_sum=3.
REQ-038 SHALL cover: random frames of 1-50 words with random in_valid/out_ready gaps, checked against a reference-model sum.
